// File: rtl/mem_transfer_ctrl_a.sv
// Threshold-filtered copy from internal memory A to a downstream memory B.
// Words of A strictly above a latched threshold are written to B, at most DEPTH_B per transfer.
module mem_transfer_ctrl_a #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH_A = 8,
  parameter int unsigned DEPTH_B = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic [WIDTH-1:0] DataInA,
  input  logic             Start,
  input  logic [WIDTH-1:0] Threshold,
  output logic [WIDTH-1:0] DataInB,
  output logic             WEB,
  output logic             IncB,
  output logic [2:0]       AddrA,
  output logic [2:0]       XferCount,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {IDLE, CLRB, READ, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem_a [DEPTH_A];
  logic [2:0]       rd_ptr;
  logic [WIDTH-1:0] thr;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] last_b;
  logic [WIDTH-1:0] rd_word;
  logic [2:0]       xfer_inc;
  logic             hit, cap, last;

  always_comb begin
    rd_word  = mem_a[rd_ptr];
    hit      = rd_word > thr;
    xfer_inc = XferCount + 3'd1;
    cap      = xfer_inc == 3'(DEPTH_B);
    last     = rd_ptr == 3'd7;
  end

  always_ff @(posedge clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = CLRB;
      CLRB:    state_nxt = READ;
      READ:    if (hit) state_nxt = WRITE;
               else if (last) state_nxt = DONE;
      WRITE:   state_nxt = (cap || last) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      AddrA     <= '0;
      rd_ptr    <= '0;
      XferCount <= '0;
      thr       <= '0;
      hold      <= '0;
      last_b    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            thr       <= Threshold;
            rd_ptr    <= '0;
            XferCount <= '0;
          end else if (LoadA) begin
            AddrA <= AddrA + 3'd1;
          end
        end
        READ: begin
          hold <= rd_word;
          if (!hit && !last) rd_ptr <= rd_ptr + 3'd1;
        end
        WRITE: begin
          XferCount <= xfer_inc;
          last_b    <= hold;
          if (!(cap || last)) rd_ptr <= rd_ptr + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory A is deliberately left out of reset so contents survive an aborted transfer.
  always_ff @(posedge clock) begin
    if (Reset && state == IDLE && LoadA && !Start) mem_a[AddrA] <= DataInA;
  end

  always_comb begin
    WEB     = 1'b0;
    IncB    = 1'b1;
    Busy    = 1'b0;
    Done    = 1'b0;
    DataInB = (state == WRITE) ? hold : last_b;
    case (state)
      CLRB:  begin IncB = 1'b0; Busy = 1'b1; end
      READ:  Busy = 1'b1;
      WRITE: begin WEB = 1'b1; IncB = 1'b0; Busy = 1'b1; end
      DONE:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_transfer_ctrl_a.sv
// Directed bench for mem_transfer_ctrl_a: a table of full transfers plus
// hand-written sequences for reset abort, load wrap and input priority.
module tb_mem_transfer_ctrl_a;

  logic       clock = 1'b0;
  logic       Reset = 1'b0;
  logic       LoadA = 1'b0;
  logic [7:0] DataInA = '0;
  logic       Start = 1'b0;
  logic [7:0] Threshold = '0;
  logic [7:0] DataInB;
  logic       WEB, IncB, Busy, Done;
  logic [2:0] AddrA, XferCount;

  int unsigned checks = 0;
  int unsigned passes = 0;

  mem_transfer_ctrl_a #(.WIDTH(8), .DEPTH_A(8), .DEPTH_B(4)) dut (
    .clock(clock), .Reset(Reset), .LoadA(LoadA), .DataInA(DataInA),
    .Start(Start), .Threshold(Threshold), .DataInB(DataInB), .WEB(WEB),
    .IncB(IncB), .AddrA(AddrA), .XferCount(XferCount), .Busy(Busy), .Done(Done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;      // word i in bits [8i+7:8i]
    logic [7:0]  thr;
    int unsigned k;         // expected number of writes
    logic [31:0] wr;        // expected written words, first in low byte
    int unsigned done_cyc;  // cycle of Done, start edge = cycle 1
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    LoadA = 1'b1;
    DataInA = d;
    tick();
    LoadA = 1'b0;
  endtask

  // Pulse Start, then watch the transfer until Done, checking every WEB beat.
  task automatic run_transfer(input string tag, input logic [7:0] thr, input int unsigned k,
                              input logic [31:0] wr, input int unsigned done_cyc);
    int unsigned seen = 0;
    int unsigned c = 0;
    bit got_done = 0;
    bit bad_enc = 0;
    Threshold = thr;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    c = 1;
    chk({tag, " clear WEB"}, {31'd0, WEB}, 32'd0);
    chk({tag, " clear IncB"}, {31'd0, IncB}, 32'd0);
    while (!got_done && c < 40) begin
      if (WEB && IncB) bad_enc = 1;
      if (WEB) begin
        if (seen < 4) chk({tag, " DataInB"}, {24'd0, DataInB}, {24'd0, wr[seen*8 +: 8]});
        seen++;
      end
      if (Done) begin
        got_done = 1;
        chk({tag, " done cycle"}, c, done_cyc);
        chk({tag, " Busy at done"}, {31'd0, Busy}, 32'd0);
      end else begin
        tick();
        c++;
      end
    end
    chk({tag, " done seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, " WEB count"}, seen, k);
    chk({tag, " XferCount"}, {29'd0, XferCount}, k);
    chk({tag, " illegal WEB+IncB"}, {31'd0, bad_enc}, 32'd0);
    tick();
  endtask

  initial begin
    vecs[0] = '{pk(10, 200, 30, 250, 5, 180, 7, 90), 8'd100, 3, {8'd0, 8'd180, 8'd250, 8'd200}, 13};
    vecs[1] = '{{8{8'hFF}}, 8'd0, 4, {4{8'hFF}}, 10};
    vecs[2] = '{pk(255, 0, 128, 255, 1, 254, 255, 77), 8'd255, 0, 32'd0, 10};
    vecs[3] = '{pk(0, 0, 0, 0, 0, 0, 0, 8'h80), 8'h7F, 1, {24'd0, 8'h80}, 11};
    vecs[4] = '{pk(8'h41, 8'h40, 8'h42, 8'h40, 8'h43, 8'h40, 8'h44, 8'h99), 8'h40, 4,
                {8'h44, 8'h43, 8'h42, 8'h41}, 13};

    Reset = 1'b0;
    tick();
    tick();
    chk("reset WEB", {31'd0, WEB}, 32'd0);
    chk("reset IncB", {31'd0, IncB}, 32'd1);
    chk("reset Busy", {31'd0, Busy}, 32'd0);
    chk("reset Done", {31'd0, Done}, 32'd0);
    chk("reset AddrA", {29'd0, AddrA}, 32'd0);
    chk("reset XferCount", {29'd0, XferCount}, 32'd0);
    chk("reset DataInB", {24'd0, DataInB}, 32'd0);
    Reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 8; i++) load_word(vecs[v].data[i*8 +: 8]);
      chk($sformatf("vec%0d AddrA wrap", v), {29'd0, AddrA}, 32'd0);
      run_transfer($sformatf("vec%0d", v), vecs[v].thr, vecs[v].k, vecs[v].wr, vecs[v].done_cyc);
    end

    // Reset while in WRITE aborts without Done; memory A survives.
    for (int i = 0; i < 8; i++) load_word(vecs[0].data[i*8 +: 8]);
    Threshold = 8'd100;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 20 && !WEB; c++) tick();
    chk("abort reached WRITE", {31'd0, WEB}, 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("abort WEB", {31'd0, WEB}, 32'd0);
    chk("abort IncB", {31'd0, IncB}, 32'd1);
    chk("abort XferCount", {29'd0, XferCount}, 32'd0);
    chk("abort Busy", {31'd0, Busy}, 32'd0);
    chk("abort Done", {31'd0, Done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort no Done", {31'd0, Done | Busy}, 32'd0);
    end
    run_transfer("restart", 8'd100, 3, {8'd0, 8'd180, 8'd250, 8'd200}, 13);

    // Nine loads wrap onto index 0; LoadA with Start and during Busy is ignored.
    for (int i = 1; i <= 8; i++) load_word(8'(i));
    load_word(8'h77);
    chk("wrap AddrA", {29'd0, AddrA}, 32'd1);
    LoadA = 1'b1;
    DataInA = 8'hEE;
    Threshold = 8'h10;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start priority AddrA", {29'd0, AddrA}, 32'd1);
    chk("start priority Busy", {31'd0, Busy}, 32'd1);
    begin
      int unsigned seen = 0;
      logic [7:0] first = '0;
      int unsigned c = 0;
      while (!Done && c < 40) begin
        if (WEB) begin
          if (seen == 0) first = DataInB;
          seen++;
        end
        tick();
        c++;
      end
      LoadA = 1'b0;
      chk("wrap done seen", {31'd0, Done}, 32'd1);
      chk("wrap WEB count", seen, 32'd1);
      chk("wrap MemA[0]", {24'd0, first}, 32'h77);
      chk("busy LoadA AddrA", {29'd0, AddrA}, 32'd1);
      chk("wrap XferCount", {29'd0, XferCount}, 32'd1);
    end
    tick();
    tick();
    chk("XferCount held", {29'd0, XferCount}, 32'd1);
    chk("DataInB held", {24'd0, DataInB}, 32'h77);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_transfer_ctrl_a.md
MEM_TRANSFER_CTRL_A -- requirements
Module: mem_transfer_ctrl_a

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH_A, default 8, number of source memory A entries; the address is 3 bits wide.
REQ-003 Parameter DEPTH_B, default 4, downstream memory B capacity, which is the maximum number of writes per transfer.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 LoadA  input  1  write DataInA into MemA[AddrA] when idle.
REQ-007 DataInA  input  WIDTH  load data for memory A.
REQ-008 Start  input  1  begin a transfer when idle.
REQ-009 Threshold  input  WIDTH  filter value, sampled on an accepted Start.
REQ-010 DataInB  output  WIDTH  word presented to downstream memory B.
REQ-011 WEB  output  1  downstream write enable.
REQ-012 IncB  output  1  downstream hold/clear control; active-low increment.
REQ-013 AddrA  output  3  current memory A load pointer.
REQ-014 XferCount  output  3  number of words written to memory B in the current or last transfer (0..4).
REQ-015 Busy  output  1  high in states CLRB, READ and WRITE.
REQ-016 Done  output  1  single-cycle transfer-complete pulse.

Function
REQ-017 The block SHALL hold internal storage MemA[0..7] x WIDTH, a 3-bit read pointer RdPtr, a latched threshold thr and a data register hold.
REQ-018 The FSM SHALL have states IDLE, CLRB, READ, WRITE and DONE.
REQ-019 WEB, IncB, Busy and Done SHALL decode from the state register only, with no input-to-output combinational path.
REQ-020 Downstream encoding SHALL be:
- hold: WEB=0, IncB=1.
- clear address: WEB=0, IncB=0.
- write and increment: WEB=1, IncB=0.
- WEB=1 with IncB=1 SHALL never be driven.
REQ-021 IDLE SHALL drive the hold encoding.
REQ-022 In IDLE with LoadA=1 and Start=0, the block SHALL write MemA[AddrA]<=DataInA and increment AddrA, wrapping 7->0.
REQ-023 In IDLE with Start=1, the block SHALL:
- set thr<=Threshold, RdPtr<=0, XferCount<=0;
- go to CLRB;
- ignore LoadA in that cycle (Start has priority).
REQ-024 CLRB SHALL last exactly one cycle, drive the clear encoding, and go to READ.
REQ-025 READ SHALL drive the hold encoding and set hold<=MemA[RdPtr], then take exactly one of these transitions:
- MemA[RdPtr] > thr (unsigned, strict): go to WRITE;
- otherwise, RdPtr==7: go to DONE;
- otherwise: RdPtr++ and stay in READ.
REQ-026 WRITE SHALL last one cycle, with DataInB=hold, WEB=1, IncB=0, and XferCount++.
REQ-027 On leaving WRITE, the block SHALL go to DONE if the incremented XferCount equals DEPTH_B or RdPtr==7; otherwise it SHALL do RdPtr++ and go to READ.
REQ-028 DONE SHALL last one cycle, with Done=1, the hold encoding and Busy=0, then go to IDLE.
REQ-029 DataInB SHALL hold its last written value outside WRITE.
REQ-030 XferCount SHALL hold its value until the next accepted Start.
REQ-031 LoadA and Start SHALL be ignored in every state except IDLE.
REQ-032 Latency: with N words examined and K words written, Done SHALL assert 2+N+K cycles after the Start edge.

Reset
REQ-033 When Reset=0 at a clock edge, the block SHALL set:
- state=IDLE;
- AddrA=0, RdPtr=0, XferCount=0, DataInB=0, thr=0;
- WEB=0, IncB=1, Busy=0, Done=0.
REQ-034 MemA contents SHALL NOT be reset.
REQ-035 Reset SHALL take priority over all inputs and over any state.
REQ-036 Reset during a transfer SHALL abort it without a Done pulse.

Verification
REQ-037 Scenario: Reset=0 for 2 cycles -> WEB=0, IncB=1, Busy=0, Done=0, AddrA=0, XferCount=0, DataInB=0.
REQ-038 Scenario: load 10,200,30,250,5,180,7,90, Threshold=100, Start -> the required response is:
- one clear cycle (WEB=0, IncB=0);
- WEB pulses carrying DataInB 200, 250, 180;
- XferCount=3;
- Done at cycle 13 after the Start edge.
REQ-039 Scenario: all words 255, Threshold=0, Start -> exactly 4 WEB pulses of 255 (indices 0..3), XferCount=4, Done at cycle 10 after the Start edge, and indices 4..7 never read.
REQ-040 Scenario: Threshold=255 with any contents, Start -> no WEB pulse, XferCount=0, Done at cycle 10 after the Start edge.
REQ-041 Scenario: Reset=0 while in WRITE -> next cycle IDLE with WEB=0, IncB=1, XferCount=0 and no Done; then Start again -> the transfer restarts with a clear cycle.
REQ-042 Scenario: 9 LoadA words, the 9th being 0x77 -> MemA[0]=0x77 and AddrA=1; then LoadA and Start in the same cycle -> no write, AddrA stays 1, transfer begins; then LoadA while Busy=1 -> ignored.
